// File: rtl/debug_ctrl_pkg.sv
// Shared types and default timing constants for the debug step controller.
package debug_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_HALT       = 2'd0,
    ST_WAIT_FRAME = 2'd1,
    ST_ADVANCE    = 2'd2,
    ST_RUN        = 2'd3
  } state_t;

  localparam int DEBOUNCE_CYCLES_DEF = 250000;
  localparam int RUN_DIV_DEF         = 2500000;

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop synchroniser, stability down-counter,
// accepted-level register and a one-cycle pulse on the accepted rising edge.
module btn_debounce #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_btn,
  output logic o_rise
);

  localparam int CW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CW-1:0] C_LOAD = CW'(STABLE_CYCLES - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_level;
  logic          r_rise;
  logic [2:0]    r_settle;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1  <= 1'b0;
      r_sync2  <= 1'b0;
      r_level  <= 1'b0;
      r_rise   <= 1'b0;
      r_settle <= '0;
      r_cnt    <= C_LOAD;
    end else begin
      r_sync1  <= i_btn;
      r_sync2  <= r_sync1;
      r_settle <= {r_settle[1:0], 1'b1};
      r_rise   <= 1'b0;
      // Until the synchroniser holds a real sample, adopt its level silently
      // so a button held through reset is not seen as a fresh press.
      if (!r_settle[2]) begin
        r_level <= r_sync2;
        r_cnt   <= C_LOAD;
      end else if (r_sync2 == r_level) begin
        r_cnt <= C_LOAD;
      end else if (r_cnt == '0) begin
        r_level <= r_sync2;
        r_cnt   <= C_LOAD;
        r_rise  <= r_sync2;
      end else begin
        r_cnt <= r_cnt - CW'(1);
      end
    end
  end

  assign o_rise = r_rise;

endmodule

// File: rtl/debug_step_ctrl.sv
// Core clock-enable sequencer: HALT, frame-synchronised single STEP and
// divided-rate RUN with an optional fetch-PC breakpoint.
//
// state      | meaning
// HALT       | core frozen, waiting for a step press or run switch edge
// WAIT_FRAME | step accepted, waiting for the start of vertical blank
// ADVANCE    | single cpu_en cycle, then back to HALT
// RUN        | cpu_en every RUN_DIV cycles until switch off or breakpoint
module debug_step_ctrl
  import debug_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int RUN_DIV         = RUN_DIV_DEF,
  parameter int CNT_W           = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             btn_step,
  input  logic             sw_run,
  input  logic             brk_en,
  input  logic [31:0]      brk_addr,
  input  logic [31:0]      pc_fe,
  input  logic             vblank,
  output logic             cpu_en,
  output logic             halted,
  output logic             brk_hit,
  output logic [CNT_W-1:0] step_count,
  output logic [1:0]       state_o
);

  localparam int DIV_W = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(RUN_DIV - 1);

  logic             w_step_req;
  logic             w_run_rise;
  logic             w_run_fall;
  logic             w_due;
  logic             w_brk_match;

  logic             r_run_sync1;
  logic             r_run_sync2;
  logic             r_run_d;
  logic [2:0]       r_settle;
  logic             r_vb_d;
  logic             r_vb_rise;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [DIV_W-1:0] r_div;
  logic [DIV_W-1:0] w_div_nxt;
  logic             r_skip_brk;
  logic             w_skip_nxt;
  logic             r_brk_hit;
  logic             w_brk_nxt;
  logic             r_cpu_en;
  logic             w_en_nxt;
  logic             r_halted;
  logic [CNT_W-1:0] r_step_count;

  btn_debounce #(
    .STABLE_CYCLES (DEBOUNCE_CYCLES)
  ) u_step_db (
    .clk    (clk),
    .rst_n  (reset),
    .i_btn  (btn_step),
    .o_rise (w_step_req)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_run_sync1 <= 1'b0;
      r_run_sync2 <= 1'b0;
      r_run_d     <= 1'b0;
      r_settle    <= '0;
      r_vb_d      <= 1'b0;
      r_vb_rise   <= 1'b0;
    end else begin
      r_run_sync1 <= sw_run;
      r_run_sync2 <= r_run_sync1;
      r_run_d     <= r_run_sync2;
      r_settle    <= {r_settle[1:0], 1'b1};
      r_vb_d      <= vblank;
      r_vb_rise   <= vblank & ~r_vb_d;
    end
  end

  // Edges are suppressed until the synchroniser has a valid sample, so a
  // switch already on at reset release does not start a run.
  assign w_run_rise  = r_settle[2] &  r_run_sync2 & ~r_run_d;
  assign w_run_fall  = r_settle[2] & ~r_run_sync2 &  r_run_d;
  assign w_due       = (r_div == '0);
  assign w_brk_match = brk_en && (pc_fe == brk_addr) && !r_skip_brk;

  always_comb begin
    w_state_nxt = r_state;
    w_div_nxt   = r_div;
    w_skip_nxt  = r_skip_brk;
    w_brk_nxt   = r_brk_hit;
    w_en_nxt    = 1'b0;
    case (r_state)
      ST_HALT: begin
        if (w_step_req) begin
          w_state_nxt = ST_WAIT_FRAME;
        end else if (w_run_rise) begin
          w_state_nxt = ST_RUN;
          w_div_nxt   = DIV_LOAD;
          w_skip_nxt  = 1'b1;
          w_brk_nxt   = 1'b0;
        end
      end
      ST_WAIT_FRAME: begin
        if (r_vb_rise) begin
          w_state_nxt = ST_ADVANCE;
          w_en_nxt    = 1'b1;
          w_brk_nxt   = 1'b0;
        end
      end
      ST_ADVANCE: begin
        w_state_nxt = ST_HALT;
      end
      ST_RUN: begin
        if (w_run_fall) begin
          w_state_nxt = ST_HALT;
        end else begin
          w_div_nxt = w_due ? DIV_LOAD : (r_div - DIV_W'(1));
          if (w_due) begin
            if (w_brk_match) begin
              w_state_nxt = ST_HALT;
              w_brk_nxt   = 1'b1;
            end else begin
              w_en_nxt   = 1'b1;
              w_skip_nxt = 1'b0;
            end
          end
        end
      end
      default: begin
        w_state_nxt = ST_HALT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= ST_HALT;
      r_div        <= '0;
      r_skip_brk   <= 1'b0;
      r_brk_hit    <= 1'b0;
      r_cpu_en     <= 1'b0;
      r_halted     <= 1'b1;
      r_step_count <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_div      <= w_div_nxt;
      r_skip_brk <= w_skip_nxt;
      r_brk_hit  <= w_brk_nxt;
      r_cpu_en   <= w_en_nxt;
      r_halted   <= (w_state_nxt == ST_HALT);
      if (r_cpu_en) begin
        r_step_count <= r_step_count + CNT_W'(1);
      end
    end
  end

  assign cpu_en     = r_cpu_en;
  assign halted     = r_halted;
  assign brk_hit    = r_brk_hit;
  assign step_count = r_step_count;
  assign state_o    = r_state;

endmodule

// File: tb/tb_debug_step_ctrl.sv
// Self-checking bench for debug_step_ctrl with DEBOUNCE_CYCLES=4, RUN_DIV=3.
module tb_debug_step_ctrl;

  localparam int DB  = 4;
  localparam int DIV = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        btn_step = 1'b0;
  logic        sw_run = 1'b0;
  logic        brk_en = 1'b0;
  logic [31:0] brk_addr = '0;
  logic [31:0] pc_fe = '0;
  logic        vblank = 1'b0;
  logic        cpu_en;
  logic        halted;
  logic        brk_hit;
  logic [15:0] step_count;
  logic [1:0]  state_o;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [15:0] exp_cnt = '0;
  logic        exp_brk = 1'b0;

  debug_step_ctrl #(
    .DEBOUNCE_CYCLES (DB),
    .RUN_DIV         (DIV),
    .CNT_W           (16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .btn_step   (btn_step),
    .sw_run     (sw_run),
    .brk_en     (brk_en),
    .brk_addr   (brk_addr),
    .pc_fe      (pc_fe),
    .vblank     (vblank),
    .cpu_en     (cpu_en),
    .halted     (halted),
    .brk_hit    (brk_hit),
    .step_count (step_count),
    .state_o    (state_o)
  );

  always #20 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  typedef struct {
    int glitches;
    int hold;
    int vb_wait;
    bit exp_pulse;
  } step_vec_t;

  step_vec_t vecs[5];

  // Button pattern (2-cycle glitches, then a hold), then one vblank rise.
  task automatic step_press(input int g, input int h, input int vbw, input bit exp);
    @(negedge clk);
    for (int i = 0; i < g; i++) begin
      btn_step = 1'b1; repeat (2) @(negedge clk);
      btn_step = 1'b0; repeat (2) @(negedge clk);
    end
    btn_step = 1'b1; repeat (h) @(negedge clk);
    btn_step = 1'b0; repeat (8 + vbw) @(negedge clk);
    chk("step_wait_state", state_o, exp ? 32'd1 : 32'd0);
    vblank = 1'b1;
    for (int e = 1; e <= 4; e++) begin
      bit en_e;
      int st_e;
      @(posedge clk); #1;
      en_e = exp && (e == 2);
      st_e = !exp ? 0 : (e == 1) ? 1 : (e == 2) ? 2 : 0;
      if (en_e) begin
        exp_cnt++;
        exp_brk = 1'b0;
      end
      chk("step_en", cpu_en, en_e);
      chk("step_state", state_o, st_e);
      if (e >= 3) chk("step_brk", brk_hit, exp_brk);
    end
    @(negedge clk) vblank = 1'b0;
    repeat (2) @(negedge clk);
    chk("step_count", step_count, exp_cnt);
    chk("step_halted", halted, 1);
  endtask

  // RUN session. Model: entry 3 edges after the switch edge, enable due every
  // DIV cycles after entry, PC advances by 4 per issued pulse (or is held);
  // first due enable ignores the breakpoint; halt at the first matching due.
  task automatic run_session(input bit en, input logic [31:0] brk, input bit hold,
                             input logic [31:0] p0, input int m_in);
    int m, h, p, t_stop, t_drop, npulse;
    m = m_in;
    h = 0;
    for (int j = 1; j <= m + 1 && h == 0; j++) begin
      logic [31:0] pcj;
      pcj = hold ? p0 : p0 + 32'(4 * (j - 1));
      if (j >= 2 && en && pcj == brk) h = j;
    end
    if (h == m + 1) m = m + 1;
    p      = (h != 0) ? h - 1 : m;
    t_drop = 3 + DIV * p;
    t_stop = (h != 0) ? 3 + DIV * h : t_drop + 3;
    npulse = 0;
    brk_en = en; brk_addr = brk; pc_fe = p0; sw_run = 1'b0;
    repeat (4) @(negedge clk);
    sw_run = 1'b1;
    for (int t = 1; t <= t_stop + 2; t++) begin
      bit en_t;
      @(posedge clk); #1;
      en_t = (t >= 3 + DIV) && (t % DIV == 0) && (t / DIV - 1 <= p);
      if (t == 3) exp_brk = 1'b0;
      if (h != 0 && t == t_stop) exp_brk = 1'b1;
      chk("run_en", cpu_en, en_t);
      chk("run_halted", halted, !(t >= 3 && t < t_stop));
      chk("run_brk", brk_hit, exp_brk);
      if (en_t) begin
        exp_cnt++;
        npulse++;
        if (!hold) pc_fe = p0 + 32'(4 * npulse);
      end
      if (h == 0 && t == t_drop) begin
        @(negedge clk) sw_run = 1'b0;
      end
    end
    sw_run = 1'b0;
    repeat (4) @(negedge clk);
    chk("run_count", step_count, exp_cnt);
    chk("run_state", state_o, 0);
  endtask

  initial begin
    vecs[0] = '{glitches: 2, hold: 10, vb_wait: 3, exp_pulse: 1'b1};
    vecs[1] = '{glitches: 0, hold: 3,  vb_wait: 0, exp_pulse: 1'b0};
    vecs[2] = '{glitches: 0, hold: 4,  vb_wait: 5, exp_pulse: 1'b1};
    vecs[3] = '{glitches: 1, hold: 2,  vb_wait: 0, exp_pulse: 1'b0};
    vecs[4] = '{glitches: 0, hold: 6,  vb_wait: 1, exp_pulse: 1'b1};

    // Reset with button and run switch both held active.
    sw_run = 1'b1; btn_step = 1'b1;
    #5 reset = 1'b0;
    #1;
    chk("rst_halted", halted, 1);
    chk("rst_en", cpu_en, 0);
    chk("rst_count", step_count, 0);
    chk("rst_state", state_o, 0);
    chk("rst_brk", brk_hit, 0);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      chk("rst_no_pulse", cpu_en, 0);
    end
    chk("rst_halted_after", halted, 1);
    chk("rst_state_after", state_o, 0);
    @(negedge clk);
    btn_step = 1'b0; sw_run = 1'b0;
    repeat (12) @(negedge clk);

    for (int i = 0; i < 5; i++)
      step_press(vecs[i].glitches, vecs[i].hold, vecs[i].vb_wait, vecs[i].exp_pulse);

    // Plain run of 5 pulses, switch dropped right after the 5th.
    run_session(1'b0, 32'h0, 1'b0, 32'h0, 5);

    // Breakpoint at 0x10 with PC advancing 0,4,8,C,10.
    run_session(1'b1, 32'h10, 1'b0, 32'h0, 8);

    // Step off the breakpoint, then rerun with PC parked on it.
    step_press(0, 10, 2, 1'b1);
    run_session(1'b1, 32'h10, 1'b1, 32'h10, 4);

    for (int it = 0; it < 8; it++) begin
      bit          r_en, r_hold;
      logic [31:0] r_p0, r_brk;
      r_en   = 1'($urandom_range(0, 1));
      r_hold = ($urandom_range(0, 3) == 0);
      r_p0   = 32'(4 * $urandom_range(0, 3));
      r_brk  = r_p0 + 32'(4 * $urandom_range(0, 5));
      run_session(r_en, r_brk, r_hold, r_p0, int'($urandom_range(2, 6)));
    end

    // Reset while waiting for the frame aborts the pending step.
    @(negedge clk);
    btn_step = 1'b1; repeat (10) @(negedge clk);
    btn_step = 1'b0; repeat (8) @(negedge clk);
    chk("abort_wait_state", state_o, 1);
    reset = 1'b0;
    #1;
    exp_cnt = '0; exp_brk = 1'b0;
    chk("abort_state", state_o, 0);
    chk("abort_count", step_count, 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    vblank = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk("abort_no_pulse", cpu_en, 0);
    end
    @(negedge clk) vblank = 1'b0;
    chk("abort_count_after", step_count, exp_cnt);
    chk("abort_halted", halted, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
